compute_histogram: RTL and testbench

COMPUTE_HISTOGRAM -- requirements
Module: compute_histogram

---
 rtl/compute_histogram_pkg.sv | 24 ++
 rtl/compute_histogram_if.sv | 29 ++
 rtl/compute_histogram_bank.sv | 51 +++++
 rtl/compute_histogram.sv | 135 +++++++++++++
 tb/tb_compute_histogram.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/compute_histogram_pkg.sv
// Shared constants, FSM state encoding and bin arithmetic for the histogram block.
package compute_histogram_pkg;

  localparam int X_BINS = 240;
  localparam int Y_BINS = 180;
  localparam int BIN_W  = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  // Increment a bin value, sticking at full scale instead of wrapping.
  function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
    logic [BIN_W-1:0] r;
    if (v == {BIN_W{1'b1}}) r = v;
    else                    r = v + {{(BIN_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/compute_histogram_if.sv
// Pixel stream, command and readout signals of the histogram block.
interface compute_histogram_if;
  import compute_histogram_pkg::*;

  logic [ADDR_W-1:0] xAddress;
  logic [ADDR_W-1:0] yAddress;
  logic              pixelData;
  logic              startHistogram;
  logic              histogramDone;
  logic              readHistogram;
  logic              clearHistogram;
  logic [BIN_W-1:0]  xHistogramOut;
  logic [BIN_W-1:0]  yHistogramOut;
  logic              xValid;
  logic              yValid;
  logic              histogramClear;

  modport master (
    output xAddress, yAddress, pixelData, startHistogram, histogramDone,
           readHistogram, clearHistogram,
    input  xHistogramOut, yHistogramOut, xValid, yValid, histogramClear
  );

  modport slave (
    input  xAddress, yAddress, pixelData, startHistogram, histogramDone,
           readHistogram, clearHistogram,
    output xHistogramOut, yHistogramOut, xValid, yValid, histogramClear
  );
endinterface

// File: rtl/compute_histogram_bank.sv
// One axis of bins: saturating increment, clear-by-index and registered read.
module histogram_bank
  import compute_histogram_pkg::*;
#(
  parameter int DEPTH = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [BIN_W-1:0]  rd_data
);

  logic [BIN_W-1:0] mem_q [DEPTH];
  logic [BIN_W-1:0] mem_d [DEPTH];
  logic [BIN_W-1:0] rd_data_q;
  logic [BIN_W-1:0] rd_data_d;

  // Next bin contents and read data; out-of-range indices leave the bank untouched.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = {BIN_W{1'b0}};
    if (clr_en && (clr_idx < ADDR_W'(DEPTH))) begin
      mem_d[clr_idx] = {BIN_W{1'b0}};
    end else if (inc_en && (inc_idx < ADDR_W'(DEPTH))) begin
      mem_d[inc_idx] = sat_inc(mem_q[inc_idx]);
    end else begin
      mem_d = mem_q;
    end
    if (rd_en && (rd_idx < ADDR_W'(DEPTH))) rd_data_d = mem_q[rd_idx];
    else                                    rd_data_d = {BIN_W{1'b0}};
  end

  // Bin storage and read register; reset zeroes every bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {BIN_W{1'b0}};
      rd_data_q <= {BIN_W{1'b0}};
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/compute_histogram.sv
// Column/row histogram of a binary image: accumulate, read out, clear.
module compute_histogram
  import compute_histogram_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  compute_histogram_if.slave  bus
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(X_BINS - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(Y_BINS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic              x_done_q, x_done_d, y_done_q, y_done_d;
  logic              x_valid_q, x_valid_d, y_valid_q, y_valid_d;
  logic              hist_clear_q, hist_clear_d;
  logic              x_inc, y_inc, x_clr, y_clr, x_rd, y_rd;
  logic [BIN_W-1:0]  x_rd_data, y_rd_data;

  // Command decode, counter stepping and bank control for each state.
  always_comb begin
    state_d      = state_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    x_done_d     = x_done_q;
    y_done_d     = y_done_q;
    x_valid_d    = 1'b0;
    y_valid_d    = 1'b0;
    hist_clear_d = 1'b0;
    x_inc        = 1'b0;
    y_inc        = 1'b0;
    x_clr        = 1'b0;
    y_clr        = 1'b0;
    x_rd         = 1'b0;
    y_rd         = 1'b0;
    case (state_q)
      IDLE: begin
        x_cnt_d  = {ADDR_W{1'b0}};
        y_cnt_d  = {ADDR_W{1'b0}};
        x_done_d = 1'b0;
        y_done_d = 1'b0;
        if (bus.clearHistogram)      state_d = CLEAR;
        else if (bus.startHistogram) state_d = ACCUM;
        else if (bus.readHistogram)  state_d = READ;
        else                         state_d = IDLE;
      end
      ACCUM: begin
        // The end marker wins over a pixel presented in the same cycle.
        if (bus.histogramDone) begin
          state_d = IDLE;
        end else if (bus.pixelData) begin
          x_inc = 1'b1;
          y_inc = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end
      READ: begin
        x_rd      = !x_done_q;
        y_rd      = !y_done_q;
        x_valid_d = x_rd;
        y_valid_d = y_rd;
        if (x_rd && (x_cnt_q == X_LAST)) x_done_d = 1'b1;
        else if (x_rd)                   x_cnt_d  = x_cnt_q + 8'd1;
        else                             x_done_d = x_done_q;
        if (y_rd && (y_cnt_q == Y_LAST)) y_done_d = 1'b1;
        else if (y_rd)                   y_cnt_d  = y_cnt_q + 8'd1;
        else                             y_done_d = y_done_q;
        if (x_done_d && y_done_d) state_d = IDLE;
        else                      state_d = READ;
      end
      CLEAR: begin
        x_clr = 1'b1;
        y_clr = !y_done_q;
        if (y_clr && (y_cnt_q == Y_LAST)) y_done_d = 1'b1;
        else if (y_clr)                   y_cnt_d  = y_cnt_q + 8'd1;
        else                              y_done_d = y_done_q;
        if (x_cnt_q == X_LAST) begin
          hist_clear_d = 1'b1;
          state_d      = IDLE;
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters, done flags and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_cnt_q      <= {ADDR_W{1'b0}};
      y_cnt_q      <= {ADDR_W{1'b0}};
      x_done_q     <= 1'b0;
      y_done_q     <= 1'b0;
      x_valid_q    <= 1'b0;
      y_valid_q    <= 1'b0;
      hist_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      x_done_q     <= x_done_d;
      y_done_q     <= y_done_d;
      x_valid_q    <= x_valid_d;
      y_valid_q    <= y_valid_d;
      hist_clear_q <= hist_clear_d;
    end
  end

  histogram_bank #(.DEPTH(X_BINS)) u_x_bank (
    .clk(clk), .reset(reset),
    .inc_en(x_inc), .inc_idx(bus.xAddress),
    .clr_en(x_clr), .clr_idx(x_cnt_q),
    .rd_en(x_rd),   .rd_idx(x_cnt_q),
    .rd_data(x_rd_data)
  );

  histogram_bank #(.DEPTH(Y_BINS)) u_y_bank (
    .clk(clk), .reset(reset),
    .inc_en(y_inc), .inc_idx(bus.yAddress),
    .clr_en(y_clr), .clr_idx(y_cnt_q),
    .rd_en(y_rd),   .rd_idx(y_cnt_q),
    .rd_data(y_rd_data)
  );

  assign bus.xHistogramOut  = x_rd_data;
  assign bus.yHistogramOut  = y_rd_data;
  assign bus.xValid         = x_valid_q;
  assign bus.yValid         = y_valid_q;
  assign bus.histogramClear = hist_clear_q;

endmodule

// File: tb/tb_compute_histogram.sv
// Randomised bench for compute_histogram against a per-bin counting model.
module tb_compute_histogram;
  import compute_histogram_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  compute_histogram_if bus();
  compute_histogram dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int xh[X_BINS];
  int yh[Y_BINS];

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    foreach (xh[i]) xh[i] = 0;
    foreach (yh[i]) yh[i] = 0;
  endtask

  // Reference: each counted pixel adds one to its column and row bin, capped at 255.
  task automatic model_hit(input int x, input int y);
    if (x < X_BINS) xh[x] = (xh[x] + 1 > 255) ? 255 : xh[x] + 1;
    if (y < Y_BINS) yh[y] = (yh[y] + 1 > 255) ? 255 : yh[y] + 1;
  endtask

  // Called at a negedge; command is high for exactly one rising edge.
  task automatic pulse(input bit s, input bit r, input bit c);
    bus.startHistogram = s;
    bus.readHistogram  = r;
    bus.clearHistogram = c;
    @(negedge clk);
    bus.startHistogram = 1'b0;
    bus.readHistogram  = 1'b0;
    bus.clearHistogram = 1'b0;
  endtask

  // One pixel while accumulating; model counts it when pixelData is set.
  task automatic accum_pixel(input int x, input int y, input bit p);
    bus.xAddress  = 8'(x);
    bus.yAddress  = 8'(y);
    bus.pixelData = p;
    if (p) model_hit(x, y);
    @(negedge clk);
  endtask

  // End marker held two cycles with a live pixel that must not be counted.
  task automatic end_accum();
    bus.pixelData     = 1'b1;
    bus.histogramDone = 1'b1;
    repeat (2) @(negedge clk);
    bus.histogramDone = 1'b0;
    bus.pixelData     = 1'b0;
  endtask

  task automatic do_read(input string tag);
    int xn = 0, yn = 0, xf = -1, yf = -1, xl = -1, yl = -1, junk = 0;
    pulse(1'b0, 1'b1, 1'b0);
    check_eq({tag, "_lat0"}, int'(bus.xValid | bus.yValid), 0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.xValid) begin
        if (xn < X_BINS) check_eq($sformatf("%s_x%0d", tag, xn), int'(bus.xHistogramOut), xh[xn]);
        xn++;
        if (xf < 0) xf = c;
        xl = c;
      end else if (bus.xHistogramOut != 8'd0) junk++;
      if (bus.yValid) begin
        if (yn < Y_BINS) check_eq($sformatf("%s_y%0d", tag, yn), int'(bus.yHistogramOut), yh[yn]);
        yn++;
        if (yf < 0) yf = c;
        yl = c;
      end else if (bus.yHistogramOut != 8'd0) junk++;
    end
    check_eq({tag, "_xcount"}, xn, X_BINS);
    check_eq({tag, "_ycount"}, yn, Y_BINS);
    check_eq({tag, "_xfirst"}, xf, 0);
    check_eq({tag, "_yfirst"}, yf, 0);
    check_eq({tag, "_xcontig"}, xl - xf + 1, xn);
    check_eq({tag, "_ycontig"}, yl - yf + 1, yn);
    check_eq({tag, "_idle_out_zero"}, junk, 0);
    check_eq({tag, "_state_idle"}, int'(dut.state_q), 0);
  endtask

  task automatic do_clear(input string tag, input bit with_start);
    int n = 0, first = -1;
    pulse(with_start, 1'b0, 1'b1);
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (bus.histogramClear) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check_eq({tag, "_pulses"}, n, 1);
    check_eq({tag, "_latency"}, first, 240);
    model_zero();
  endtask

  initial begin
    int ign_clr, ign_val;
    reset              = 1'b1;
    bus.xAddress       = 8'd0;
    bus.yAddress       = 8'd0;
    bus.pixelData      = 1'b0;
    bus.startHistogram = 1'b0;
    bus.histogramDone  = 1'b0;
    bus.readHistogram  = 1'b0;
    bus.clearHistogram = 1'b0;
    model_zero();
    repeat (3) @(negedge clk);
    check_eq("rst_xvalid", int'(bus.xValid), 0);
    check_eq("rst_yvalid", int'(bus.yValid), 0);
    check_eq("rst_clrpulse", int'(bus.histogramClear), 0);
    check_eq("rst_xout", int'(bus.xHistogramOut), 0);
    reset = 1'b0;

    // Fresh reset reads back all zeros.
    do_read("rst_read");

    // Full raster: every column seen 180 times, every row 240 times.
    pulse(1'b1, 1'b0, 1'b0);
    for (int y = 0; y < Y_BINS; y++)
      for (int x = 0; x < X_BINS; x++) accum_pixel(x, y, 1'b1);
    bus.xAddress = 8'd10;
    bus.yAddress = 8'd20;
    end_accum();
    do_read("raster");

    do_clear("clr1", 1'b0);
    do_read("after_clr");

    // Random pixels incl. out-of-range addresses, saturation and corner bins.
    bus.xAddress  = 8'd0;
    bus.yAddress  = 8'd0;
    bus.pixelData = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++)
      accum_pixel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++) accum_pixel(3, 3, 1'b1);
    for (int i = 0; i < 10; i++) accum_pixel(239, 179, 1'b1);
    for (int i = 0; i < 5; i++) accum_pixel(240, 180, 1'b1);
    bus.xAddress = 8'd239;
    bus.yAddress = 8'd179;
    end_accum();
    do_read("random");

    // Clear and read during accumulation are ignored.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    ign_clr = 0;
    ign_val = 0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (bus.histogramClear) ign_clr++;
      if (bus.xValid || bus.yValid) ign_val++;
    end
    check_eq("accum_ignore_clear", ign_clr, 0);
    check_eq("accum_ignore_read", ign_val, 0);
    for (int i = 0; i < 200; i++)
      accum_pixel(int'($urandom_range(0, 239)), int'($urandom_range(0, 179)), 1'b1);
    end_accum();
    do_read("ignored");

    // Clear and start together: clear wins.
    do_clear("clr_start", 1'b1);
    do_read("clr_won");

    // Refill, then reset in the middle of a readout.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      accum_pixel(int'($urandom_range(0, 239)), int'($urandom_range(0, 179)), 1'b1);
    end_accum();
    pulse(1'b0, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    check_eq("midread_xvalid", int'(bus.xValid), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_xvalid", int'(bus.xValid), 0);
    check_eq("midrst_yvalid", int'(bus.yValid), 0);
    check_eq("midrst_state", int'(dut.state_q), 0);
    reset = 1'b0;
    model_zero();
    do_read("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
